commit_trace_buffer: RTL
========================

Name: commit_trace_buffer

Overview:
- Synthesizable successor to the bench-side register-dump probe.
- Sits on the core debug port: snapshots the register file and PC on pre_execution, diffs them on post_execution, and pushes one compact commit record per retired instruction into a FIFO.
- The FIFO is drained over a valid/ready stream toward a trace sink (UART or logger).
- Parametrised in XLEN, register count, FIFO depth and sequence width; adds overflow and protocol-error tracking.

Parameters:
- XLEN, 32, register and PC width.
- NUM_REGS, 32, architectural registers observed (2..64).
- DEPTH, 16, FIFO entries (power of two, ≥2).
- SEQ_W, 8, sequence number width.
- SKIP_R0, 1, if 1 register index 0 is excluded from the diff.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous and active-low.
- enable  in  1  capture enable; when 0, pre/post events are ignored.
- clear  in  1  synchronous pulse; clears overflow, drop_count and proto_err.
- pre_execution  in  1  pulse before an instruction executes.
- post_execution  in  1  pulse after it retires.
- pc_debug  in  XLEN  current PC.
- debug_regs_flat  in  NUM_REGS*XLEN  register file; register i at bits [i*XLEN +: XLEN].
- trace_valid  out  1  record available.
- trace_ready  in  1  sink accepts.
- trace_pc  out  XLEN  PC latched at pre_execution.
- trace_rd  out  $clog2(NUM_REGS)  lowest-index changed register.
- trace_data  out  XLEN  new value of trace_rd.
- trace_nchg  out  $clog2(NUM_REGS+1)  number of registers changed.
- trace_seq  out  SEQ_W  event sequence number.
- fifo_level  out  $clog2(DEPTH+1)  occupied entries.
- overflow  out  1  sticky; set when a record was dropped.
- drop_count  out  16  saturating count of dropped records.
- proto_err  out  1  sticky; set on pre/post ordering violation.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0 and FIFO empty.
  - State IDLE; snapshot and seq counter cleared.
- FSM states:
  - IDLE: pre_execution&enable → latch regs and PC → ARMED.
  - ARMED: post_execution&enable → generate record → IDLE.
  - ARMED: pre_execution without post → proto_err=1, re-snapshot, stay ARMED.
  - IDLE: post_execution → proto_err=1, no record, seq unchanged.
- Simultaneous pre and post in ARMED: complete the current record with the post data, then re-arm from the same-cycle snapshot; stay ARMED.
- Diff:
  - Combinational compare of debug_regs_flat against the snapshot in the post cycle.
  - trace_rd is the lowest changed index; trace_nchg is the popcount of changed registers.
  - No change → rd=0, data=0, nchg=0; the record is still pushed.
  - SKIP_R0 masks index 0 from the compare.
- Latency: record written at the clock edge sampling post_execution. trace_valid is visible the following cycle when the FIFO was empty. Outputs are driven from the FIFO head register, first-word-fall-through.
- Handshake:
  - Pop on trace_valid&trace_ready.
  - trace_valid holds and record fields stay stable until accepted.
- Full FIFO:
  - Push with pop in the same cycle → accepted, level unchanged.
  - Push without pop → record dropped, overflow=1, drop_count+1 (saturates at 0xFFFF).
- seq increments on every post event that generates a record, accepted or dropped, so gaps expose drops. Wraps modulo 2^SEQ_W.
- clear coincident with a drop: the drop wins (overflow=1, drop_count=1).
- enable=0 while ARMED: state is held; events are ignored until enable returns.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined: adds output trace_ts (32 bits), the free-running cycle counter value at the post edge, stored per record. The counter resets to 0 and wraps.
- Undefined: no counter, no port, and record width is reduced.

Decomposition:
- Package trace_pkg holds:
  - trace_state_t enum {IDLE, ARMED}.
  - trace_rec_t packed struct (pc, rd, data, nchg, seq[, ts]).
  - DROP_W=16 constant.
- Sub-module trace_fifo: a generic synchronous FWFT FIFO (DEPTH, element type). It exposes full, empty and level, and uses the same clk/rst.

Test Plan:
- Reset, then pre (PC=0x100, all regs 0), then x5 set to 0xDEADBEEF and post → one record: pc=0x100, rd=5, data=0xDEADBEEF, nchg=1, seq=0; trace_valid one cycle later.
- x3=1 and x7=2 changed in one instruction → rd=3, data=1, nchg=2.
- trace_ready=0, DEPTH=16, 18 pre/post pairs → fifo_level=16, overflow=1, drop_count=2. Drain yields seq 0..15; next accepted record has seq=18.
- post without pre → proto_err=1, no record; clear pulse → proto_err=0.
- SKIP_R0=1, snapshot of x0 forced different → nchg=0, rd=0, record still pushed.
- rst asserted mid-ARMED with 3 queued entries → trace_valid=0, fifo_level=0, next post flags proto_err.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: shared types and constants for the commit trace buffer.
// Build option: define TRACE_TIMESTAMP_EN to add a per-record cycle timestamp.
package trace_pkg;

  // Width of the saturating dropped-record counter.
  localparam int DROP_W = 16;
  // Width of the optional free-running timestamp.
  localparam int TS_W   = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } trace_state_t;

  // Record layout at the default sizing (XLEN=32, NUM_REGS=32, SEQ_W=8).
  // The top rebuilds the same field order from its own parameters.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [5:0]  nchg;
    logic [7:0]  seq;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: generic synchronous first-word-fall-through FIFO.
// The head element is presented on dout whenever the FIFO is not empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [LW-1:0]  level_reg;
  logic           do_push;
  logic           do_pop;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_reg];
  assign level   = level_reg;

  // Storage write; left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      level_reg <= level_reg + 1'b1;
      else if (!do_push && do_pop) level_reg <= level_reg - 1'b1;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: snapshots the register file and PC on pre_execution,
// diffs on post_execution and queues one compact commit record per retired
// instruction, drained over a valid/ready stream.
// Build option: TRACE_TIMESTAMP_EN adds trace_ts (cycle count at the post edge).
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int DEPTH    = 16,
  parameter int SEQ_W    = 8,
  parameter int SKIP_R0  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          pre_execution,
  input  logic                          post_execution,
  input  logic [XLEN-1:0]               pc_debug,
  input  logic [NUM_REGS*XLEN-1:0]      debug_regs_flat,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [XLEN-1:0]               trace_pc,
  output logic [$clog2(NUM_REGS)-1:0]   trace_rd,
  output logic [XLEN-1:0]               trace_data,
  output logic [$clog2(NUM_REGS+1)-1:0] trace_nchg,
  output logic [SEQ_W-1:0]              trace_seq,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_level,
  output logic                          overflow,
  output logic [DROP_W-1:0]             drop_count,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]               trace_ts,
`endif
  output logic                          proto_err
);

  localparam int RD_W   = $clog2(NUM_REGS);
  localparam int NCHG_W = $clog2(NUM_REGS+1);
  // Index 0 drops out of the compare when it is hardwired in the core.
  localparam logic [NUM_REGS-1:0] CMP_MASK = ~(NUM_REGS'(SKIP_R0 != 0));

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [RD_W-1:0]   rd;
    logic [XLEN-1:0]   data;
    logic [NCHG_W-1:0] nchg;
    logic [SEQ_W-1:0]  seq;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } rec_t;

  trace_state_t              state_reg;
  logic [NUM_REGS*XLEN-1:0]  snap_reg;
  logic [XLEN-1:0]           pc_reg;
  logic [SEQ_W-1:0]          seq_reg;
  logic                      proto_err_reg;
  logic                      overflow_reg;
  logic [DROP_W-1:0]         drop_count_reg;

  logic [NUM_REGS-1:0]       raw_changed;
  logic [NUM_REGS-1:0]       changed;
  logic [RD_W-1:0]           diff_rd;
  logic [XLEN-1:0]           diff_data;
  logic [NCHG_W-1:0]         diff_nchg;

  logic                      pre_ev;
  logic                      post_ev;
  logic                      push;
  logic                      pop_fire;
  logic                      drop;
  logic                      fifo_full;
  logic                      fifo_empty;
  rec_t                      rec_in;
  rec_t                      rec_head;
  rec_t                      rec_out;

  assign pre_ev  = pre_execution & enable;
  assign post_ev = post_execution & enable;

  // Per-register compare of the live file against the snapshot.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_cmp
      assign raw_changed[gi] =
        (debug_regs_flat[gi*XLEN +: XLEN] != snap_reg[gi*XLEN +: XLEN]);
    end
  endgenerate

  assign changed = raw_changed & CMP_MASK;

  // Lowest changed index with its new value, plus the number of changed registers.
  always_comb begin
    diff_rd   = '0;
    diff_data = '0;
    diff_nchg = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (changed[i]) begin
        diff_rd   = RD_W'(i);
        diff_data = debug_regs_flat[i*XLEN +: XLEN];
        diff_nchg = diff_nchg + 1'b1;
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_reg;

  // Free-running cycle counter sampled into each record.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_reg <= '0;
    else      ts_reg <= ts_reg + 1'b1;
  end
`endif

  // Assemble the record for the retiring instruction.
  always_comb begin
    rec_in      = '0;
    rec_in.pc   = pc_reg;
    rec_in.rd   = diff_rd;
    rec_in.data = diff_data;
    rec_in.nchg = diff_nchg;
    rec_in.seq  = seq_reg;
`ifdef TRACE_TIMESTAMP_EN
    rec_in.ts   = ts_reg;
`endif
  end

  assign push     = (state_reg == ARMED) && post_ev;
  assign pop_fire = trace_ready & ~fifo_empty;
  assign drop     = push & fifo_full & ~pop_fire;

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (rec_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rec_in),
    .pop   (trace_ready),
    .dout  (rec_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Capture FSM: snapshot on pre, record on post, flag ordering violations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      snap_reg      <= '0;
      pc_reg        <= '0;
      seq_reg       <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      if (push)   seq_reg <= seq_reg + 1'b1;
      if (pre_ev) begin
        snap_reg <= debug_regs_flat;
        pc_reg   <= pc_debug;
      end
      if ((state_reg == IDLE && post_ev) ||
          (state_reg == ARMED && pre_ev && !post_ev))
        proto_err_reg <= 1'b1;
      else if (clear)
        proto_err_reg <= 1'b0;
      case (state_reg)
        IDLE:    if (pre_ev) state_reg <= ARMED;
        ARMED:   if (post_ev && !pre_ev) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Drop tracking; a drop in the same cycle as clear restarts the count at one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (clear)                     drop_count_reg <= DROP_W'(1);
      else if (drop_count_reg != '1) drop_count_reg <= drop_count_reg + 1'b1;
    end else if (clear) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end
  end

  // Fields read as zero while no record is available.
  assign rec_out     = fifo_empty ? '0 : rec_head;
  assign trace_valid = ~fifo_empty;
  assign trace_pc    = rec_out.pc;
  assign trace_rd    = rec_out.rd;
  assign trace_data  = rec_out.data;
  assign trace_nchg  = rec_out.nchg;
  assign trace_seq   = rec_out.seq;
`ifdef TRACE_TIMESTAMP_EN
  assign trace_ts    = rec_out.ts;
`endif
  assign overflow    = overflow_reg;
  assign drop_count  = drop_count_reg;
  assign proto_err   = proto_err_reg;

endmodule
